// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID/EX pipeline slice: field widths, stage FSM
// encoding and the EX destination-register selection rule.
package pipeline_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int REG_ADDR_W = 3;
   localparam int ALU_OP_W   = 4;
   localparam int ALU_SRC_W  = 2;
   localparam int CNT_W      = 2;
   localparam int BCOUNT_W   = 16;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } stage_state_t;

   // A load writes ex_rs when reg_write_address is set, otherwise ex_rd.
   function automatic logic [REG_ADDR_W-1:0] dest_reg(
      input logic                  reg_write_address,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rd
   );
      return reg_write_address ? rs : rd;
   endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction currently in ID.
module load_use_detector
   import pipeline_pkg::*;
(
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic                  ex_reg_write,
   input  logic                  ex_reg_write_address,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  id_valid,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rd,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rd,
   output logic                  hazard
);

   logic [REG_ADDR_W-1:0] dest;
   logic                  ex_is_load;
   logic                  rs_match;
   logic                  rd_match;

   always_comb begin
      dest       = dest_reg(ex_reg_write_address, ex_rs, ex_rd);
      ex_is_load = ex_valid & ex_mem_read & ex_reg_write;
      rs_match   = id_uses_rs & (id_rs == dest);
      rd_match   = id_uses_rd & (id_rd == dest);
      hazard     = ex_is_load & id_valid & (rs_match | rd_match);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall control: inserts LOAD_BUBBLES
// bubbles per hazard, honours flush and downstream hold, counts bubbles.
module id_ex_stage
   import pipeline_pkg::REG_ADDR_W, pipeline_pkg::ALU_OP_W, pipeline_pkg::ALU_SRC_W,
          pipeline_pkg::CNT_W, pipeline_pkg::BCOUNT_W, pipeline_pkg::stage_state_t,
          pipeline_pkg::RUN, pipeline_pkg::STALL;
#(
   parameter int DATA_WIDTH   = pipeline_pkg::DATA_WIDTH,
   parameter int LOAD_BUBBLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  ex_hold,

   input  logic                  id_valid,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_reg_write,
   input  logic                  id_reg_write_address,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rd,
   input  logic [ALU_SRC_W-1:0]  id_alu_src_a,
   input  logic [ALU_SRC_W-1:0]  id_alu_src_b,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [DATA_WIDTH-1:0] id_pc,
   input  logic [DATA_WIDTH-1:0] id_data_rs,
   input  logic [DATA_WIDTH-1:0] id_data_rd,
   input  logic [DATA_WIDTH-1:0] id_imm,

   output logic                  ex_valid,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_reg_write,
   output logic                  ex_reg_write_address,
   output logic                  ex_uses_rs,
   output logic                  ex_uses_rd,
   output logic [ALU_SRC_W-1:0]  ex_alu_src_a,
   output logic [ALU_SRC_W-1:0]  ex_alu_src_b,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [DATA_WIDTH-1:0] ex_pc,
   output logic [DATA_WIDTH-1:0] ex_data_rs,
   output logic [DATA_WIDTH-1:0] ex_data_rd,
   output logic [DATA_WIDTH-1:0] ex_imm,

   output logic                  stall_id,
   output logic [BCOUNT_W-1:0]   bubble_count
);

   stage_state_t     state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             hazard;
   logic             load_id;
   logic             load_bubble;
   logic             count_bubble;

   load_use_detector u_detector (
      .ex_valid             (ex_valid),
      .ex_mem_read          (ex_mem_read),
      .ex_reg_write         (ex_reg_write),
      .ex_reg_write_address (ex_reg_write_address),
      .ex_rs                (ex_rs),
      .ex_rd                (ex_rd),
      .id_valid             (id_valid),
      .id_uses_rs           (id_uses_rs),
      .id_uses_rd           (id_uses_rd),
      .id_rs                (id_rs),
      .id_rd                (id_rd),
      .hazard               (hazard)
   );

   // Priority chain: reset > flush > ex_hold > stall/hazard > normal issue.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      stall_id     = 1'b0;
      load_id      = 1'b0;
      load_bubble  = 1'b0;
      count_bubble = 1'b0;
      if (reset) begin
         state_nx = RUN;
         cnt_nx   = '0;
      end else if (flush) begin
         load_bubble = 1'b1;
         state_nx    = RUN;
         cnt_nx      = '0;
      end else if (ex_hold) begin
         stall_id = 1'b1;
      end else if (state == STALL) begin
         stall_id     = 1'b1;
         load_bubble  = 1'b1;
         count_bubble = 1'b1;
         cnt_nx       = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) state_nx = RUN;
      end else if (hazard) begin
         stall_id     = 1'b1;
         load_bubble  = 1'b1;
         count_bubble = 1'b1;
         if (LOAD_BUBBLES > 1) begin
            state_nx = STALL;
            cnt_nx   = CNT_W'(LOAD_BUBBLES - 1);
         end
      end else begin
         load_id = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= RUN;
         cnt                  <= '0;
         bubble_count         <= '0;
         ex_valid             <= 1'b0;
         ex_mem_read          <= 1'b0;
         ex_mem_write         <= 1'b0;
         ex_reg_write         <= 1'b0;
         ex_reg_write_address <= 1'b0;
         ex_uses_rs           <= 1'b0;
         ex_uses_rd           <= 1'b0;
         ex_alu_src_a         <= '0;
         ex_alu_src_b         <= '0;
         ex_alu_op            <= '0;
         ex_rs                <= '0;
         ex_rd                <= '0;
         ex_pc                <= '0;
         ex_data_rs           <= '0;
         ex_data_rd           <= '0;
         ex_imm               <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (count_bubble && (bubble_count != '1)) bubble_count <= bubble_count + 1'b1;
         if (load_bubble) begin
            ex_valid             <= 1'b0;
            ex_mem_read          <= 1'b0;
            ex_mem_write         <= 1'b0;
            ex_reg_write         <= 1'b0;
            ex_reg_write_address <= 1'b0;
            ex_uses_rs           <= 1'b0;
            ex_uses_rd           <= 1'b0;
            ex_alu_src_a         <= '0;
            ex_alu_src_b         <= '0;
            ex_alu_op            <= '0;
            ex_rs                <= '0;
            ex_rd                <= '0;
            ex_pc                <= '0;
            ex_data_rs           <= '0;
            ex_data_rd           <= '0;
            ex_imm               <= '0;
         end else if (load_id) begin
            ex_valid             <= id_valid;
            ex_mem_read          <= id_mem_read;
            ex_mem_write         <= id_mem_write;
            ex_reg_write         <= id_reg_write;
            ex_reg_write_address <= id_reg_write_address;
            ex_uses_rs           <= id_uses_rs;
            ex_uses_rd           <= id_uses_rd;
            ex_alu_src_a         <= id_alu_src_a;
            ex_alu_src_b         <= id_alu_src_b;
            ex_alu_op            <= id_alu_op;
            ex_rs                <= id_rs;
            ex_rd                <= id_rd;
            ex_pc                <= id_pc;
            ex_data_rs           <= id_data_rs;
            ex_data_rd           <= id_data_rd;
            ex_imm               <= id_imm;
         end
      end
   end

endmodule
